// File: rtl/tile_map_arbiter.sv
// Tile map shared by the display and three game requesters: one map access per cycle,
// with starvation override and round-robin. Define TILE_MAP_STATS_EN for per-requester grant counters.
module tile_map_arbiter #(
   parameter int MAP_W        = 20,
   parameter int MAP_H        = 15,
   parameter int STARVE_LIMIT = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        disp_req,
   input  logic [8:0]  disp_addr,
   output logic [1:0]  disp_data,
   output logic        disp_valid,
   output logic        disp_miss,
   input  logic [2:0]  req,
   input  logic [26:0] req_addr,
   input  logic [2:0]  req_we,
   input  logic [5:0]  req_wdata,
   output logic [2:0]  gnt,
   output logic [1:0]  rd_data,
   output logic [2:0]  rd_valid,
   output logic        addr_err,
   output logic [47:0] stat_cnt
);
   localparam int         N_TILES    = MAP_W * MAP_H;
   localparam logic [9:0] TILE_LIMIT = 10'(N_TILES);
   localparam logic [3:0] STARVE_CNT = 4'(STARVE_LIMIT);

   logic [1:0] map_q [N_TILES];
   logic [3:0] wait_q [3];
   logic [1:0] rr_q;
   logic [2:0] starved;
   logic [2:0] gnt_c;
   logic       disp_gnt;
   logic [1:0] sel;
   logic       sel_valid;
   logic [8:0] acc_addr;
   logic       acc_we;
   logic [1:0] acc_wdata;
   logic       acc_ok;
   logic [1:0] acc_rd;
   logic [1:0] acc_resp;
   logic       disp_ok;
   logic [1:0] disp_rd;

   // Power-on layout: solid border plus a pillar at every even row / even column.
   function automatic logic [1:0] layout_tile(input int t);
      int r;
      int c;
      r = t / MAP_W;
      c = t % MAP_W;
      if (r == 0 || r == MAP_H - 1 || c == 0 || c == MAP_W - 1 || (r % 2 == 0 && c % 2 == 0))
         return 2'd1;
      return 2'd0;
   endfunction

   // Starved requesters beat display, display beats round-robin; rr_q names the last winner.
   always_comb begin
      starved   = '0;
      disp_gnt  = 1'b0;
      sel       = 2'd0;
      sel_valid = 1'b0;
      for (int i = 0; i < 3; i++)
         starved[i] = req[i] && (wait_q[i] >= STARVE_CNT);
      if (starved[0]) begin
         sel       = 2'd0;
         sel_valid = 1'b1;
      end else if (starved[1]) begin
         sel       = 2'd1;
         sel_valid = 1'b1;
      end else if (starved[2]) begin
         sel       = 2'd2;
         sel_valid = 1'b1;
      end else if (disp_req) begin
         disp_gnt = 1'b1;
      end else begin
         sel_valid = |req;
         case (rr_q)
            2'd0:    sel = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    sel = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
         endcase
      end
      gnt_c = sel_valid ? (3'b001 << sel) : 3'b000;
   end

   assign gnt = reset_n ? gnt_c : 3'b000;

   always_comb begin
      acc_addr  = req_addr[8:0];
      acc_we    = req_we[0];
      acc_wdata = req_wdata[1:0];
      case (sel)
         2'd1: begin
            acc_addr  = req_addr[17:9];
            acc_we    = req_we[1];
            acc_wdata = req_wdata[3:2];
         end
         2'd2: begin
            acc_addr  = req_addr[26:18];
            acc_we    = req_we[2];
            acc_wdata = req_wdata[5:4];
         end
         default: ;
      endcase
      acc_ok   = {1'b0, acc_addr} < TILE_LIMIT;
      acc_rd   = acc_ok ? map_q[acc_addr] : 2'd1;
      acc_resp = (acc_we && acc_ok) ? acc_wdata : acc_rd;
      disp_ok  = {1'b0, disp_addr} < TILE_LIMIT;
      disp_rd  = disp_ok ? map_q[disp_addr] : 2'd1;
   end

   // Completions, display result, RR pointer and saturating wait counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data    <= 2'd0;
         rd_valid   <= 3'b000;
         addr_err   <= 1'b0;
         disp_data  <= 2'd0;
         disp_valid <= 1'b0;
         disp_miss  <= 1'b0;
         rr_q       <= 2'd2;
         for (int i = 0; i < 3; i++) wait_q[i] <= 4'd0;
      end else begin
         rd_valid   <= gnt_c;
         rd_data    <= sel_valid ? acc_resp : 2'd0;
         addr_err   <= sel_valid && !acc_ok;
         disp_valid <= disp_gnt;
         disp_data  <= disp_gnt ? disp_rd : 2'd0;
         disp_miss  <= disp_req && !disp_gnt;
         if (sel_valid) rr_q <= sel;
         for (int i = 0; i < 3; i++) begin
            if (!req[i] || gnt_c[i]) wait_q[i] <= 4'd0;
            else if (wait_q[i] != 4'hF) wait_q[i] <= wait_q[i] + 4'd1;
         end
      end
   end

   // Out-of-range writes are dropped; reset reloads the fixed layout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int t = 0; t < N_TILES; t++) map_q[t] <= layout_tile(t);
      end else if (sel_valid && acc_we && acc_ok) begin
         map_q[acc_addr] <= acc_wdata;
      end
   end

`ifdef TILE_MAP_STATS_EN
   logic [15:0] stat_q [3];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) stat_q[i] <= 16'd0;
      end else begin
         for (int i = 0; i < 3; i++)
            if (gnt_c[i] && stat_q[i] != 16'hFFFF) stat_q[i] <= stat_q[i] + 16'd1;
      end
   end

   assign stat_cnt = {stat_q[2], stat_q[1], stat_q[0]};
`else
   assign stat_cnt = 48'd0;
`endif

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Self-checking bench for tile_map_arbiter: directed vector table, corner sequences and
// randomized traffic checked against a behavioural map/arbitration model.
module tb_tile_map_arbiter;
   localparam int MAP_W        = 20;
   localparam int MAP_H        = 15;
   localparam int STARVE_LIMIT = 15;
   localparam int N_TILES      = MAP_W * MAP_H;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        disp_req = 1'b0;
   logic [8:0]  disp_addr = '0;
   logic [1:0]  disp_data;
   logic        disp_valid;
   logic        disp_miss;
   logic [2:0]  req = '0;
   logic [26:0] req_addr = '0;
   logic [2:0]  req_we = '0;
   logic [5:0]  req_wdata = '0;
   logic [2:0]  gnt;
   logic [1:0]  rd_data;
   logic [2:0]  rd_valid;
   logic        addr_err;
   logic [47:0] stat_cnt;

   int total = 0;
   int bad = 0;

   int m_map [N_TILES];
   int m_wait [3];
   int m_last;

   logic [2:0] got_gnt;
   logic [2:0] exp_gnt;
   logic [2:0] exp_rd_valid;
   logic [1:0] exp_rd;
   logic       exp_err;
   logic       exp_dvalid;
   logic [1:0] exp_ddata;
   logic       exp_dmiss;

   typedef struct {
      bit         dr;
      logic [8:0] da;
      logic [2:0] r;
      logic [8:0] a;
      logic [2:0] we;
      logic [1:0] wd;
      logic [2:0] eg;
      logic [1:0] erd;
      logic       eerr;
      logic       edv;
      logic [1:0] edd;
   } vec_t;

   vec_t vecs [14];

   tile_map_arbiter #(.MAP_W(MAP_W), .MAP_H(MAP_H), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
      .disp_valid(disp_valid), .disp_miss(disp_miss),
      .req(req), .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
      .gnt(gnt), .rd_data(rd_data), .rd_valid(rd_valid), .addr_err(addr_err),
      .stat_cnt(stat_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic modelReset();
      for (int t = 0; t < N_TILES; t++) begin
         int r;
         int c;
         r = t / MAP_W;
         c = t % MAP_W;
         m_map[t] = (r == 0 || r == MAP_H - 1 || c == 0 || c == MAP_W - 1 ||
                     (r % 2 == 0 && c % 2 == 0)) ? 1 : 0;
      end
      for (int i = 0; i < 3; i++) m_wait[i] = 0;
      m_last = 2;
   endtask

   // Reference: pick the winner from the priority rules, then perform the access on the array.
   task automatic modelStep();
      int winner;
      bit disp_win;
      int a;
      winner = -1;
      disp_win = 1'b0;
      for (int i = 0; i < 3; i++)
         if (winner < 0 && req[i] && m_wait[i] >= STARVE_LIMIT) winner = i;
      if (winner < 0 && disp_req) disp_win = 1'b1;
      if (winner < 0 && !disp_win)
         for (int k = 1; k <= 3; k++)
            if (winner < 0 && req[(m_last + k) % 3]) winner = (m_last + k) % 3;
      exp_gnt = 3'b000;
      exp_rd = 2'd0;
      exp_err = 1'b0;
      exp_dvalid = disp_win;
      exp_dmiss = disp_req && !disp_win;
      exp_ddata = 2'd0;
      if (disp_win) exp_ddata = (int'(disp_addr) < N_TILES) ? 2'(m_map[disp_addr]) : 2'd1;
      if (winner >= 0) begin
         exp_gnt = 3'(1 << winner);
         a = int'(req_addr[9*winner +: 9]);
         if (a >= N_TILES) begin
            exp_rd = 2'd1;
            exp_err = 1'b1;
         end else begin
            if (req_we[winner]) m_map[a] = int'(req_wdata[2*winner +: 2]);
            exp_rd = 2'(m_map[a]);
         end
         m_last = winner;
      end
      for (int i = 0; i < 3; i++)
         m_wait[i] = (!req[i] || i == winner) ? 0 : ((m_wait[i] < 15) ? m_wait[i] + 1 : 15);
      exp_rd_valid = exp_gnt;
   endtask

   // Drive one cycle: inputs at negedge, grant sampled mid-low phase, outputs sampled after posedge.
   task automatic applyStimulus(input bit dr, input logic [8:0] da, input logic [2:0] r,
                                input logic [26:0] ra, input logic [2:0] we, input logic [5:0] wd);
      @(negedge clk);
      disp_req = dr;
      disp_addr = da;
      req = r;
      req_addr = ra;
      req_we = we;
      req_wdata = wd;
      #1;
      modelStep();
      got_gnt = gnt;
      @(posedge clk);
      #1;
   endtask

   task automatic compareAll(input string tag);
      checkOutput({tag, "_gnt"}, got_gnt, exp_gnt);
      checkOutput({tag, "_rd_valid"}, rd_valid, exp_rd_valid);
      if (exp_rd_valid != 3'b000) checkOutput({tag, "_rd_data"}, rd_data, exp_rd);
      checkOutput({tag, "_addr_err"}, addr_err, exp_err);
      checkOutput({tag, "_disp_valid"}, disp_valid, exp_dvalid);
      if (exp_dvalid) checkOutput({tag, "_disp_data"}, disp_data, exp_ddata);
      checkOutput({tag, "_disp_miss"}, disp_miss, exp_dmiss);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset_n = 1'b0;
      disp_req = 1'b1;
      req = 3'b111;
      req_we = 3'b000;
      #1;
      checkOutput("reset_gnt", gnt, 3'b000);
      @(posedge clk);
      #1;
      checkOutput("reset_outputs",
                  {stat_cnt, disp_data, disp_valid, disp_miss, rd_data, rd_valid, addr_err}, 64'd0);
      req = 3'b000;
      disp_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      modelReset();
   endtask

   initial begin
      logic [2:0] rr_exp [4];
      int         grant_cycle;
      bit         found;
      bit         pend [3];
      logic [8:0] paddr [3];
      logic       pwe [3];
      logic [1:0] pwd [3];

      //           dr    da      r       a        we      wd     eg      erd   eerr  edv   edd
      vecs[0]  = '{1'b0, 9'd0,  3'b001, 9'd0,   3'b000, 2'd0, 3'b001, 2'd1, 1'b0, 1'b0, 2'd0};
      vecs[1]  = '{1'b0, 9'd0,  3'b001, 9'd21,  3'b000, 2'd0, 3'b001, 2'd0, 1'b0, 1'b0, 2'd0};
      vecs[2]  = '{1'b0, 9'd0,  3'b001, 9'd42,  3'b000, 2'd0, 3'b001, 2'd1, 1'b0, 1'b0, 2'd0};
      vecs[3]  = '{1'b0, 9'd0,  3'b100, 9'd23,  3'b100, 2'd2, 3'b100, 2'd2, 1'b0, 1'b0, 2'd0};
      vecs[4]  = '{1'b0, 9'd0,  3'b001, 9'd23,  3'b000, 2'd0, 3'b001, 2'd2, 1'b0, 1'b0, 2'd0};
      vecs[5]  = '{1'b0, 9'd0,  3'b010, 9'd300, 3'b000, 2'd0, 3'b010, 2'd1, 1'b1, 1'b0, 2'd0};
      vecs[6]  = '{1'b0, 9'd0,  3'b010, 9'd300, 3'b010, 2'd3, 3'b010, 2'd1, 1'b1, 1'b0, 2'd0};
      vecs[7]  = '{1'b0, 9'd0,  3'b001, 9'd44,  3'b000, 2'd0, 3'b001, 2'd1, 1'b0, 1'b0, 2'd0};
      vecs[8]  = '{1'b0, 9'd0,  3'b001, 9'd299, 3'b000, 2'd0, 3'b001, 2'd1, 1'b0, 1'b0, 2'd0};
      vecs[9]  = '{1'b1, 9'd23, 3'b000, 9'd0,   3'b000, 2'd0, 3'b000, 2'd0, 1'b0, 1'b1, 2'd2};
      vecs[10] = '{1'b1, 9'd0,  3'b001, 9'd24,  3'b000, 2'd0, 3'b000, 2'd0, 1'b0, 1'b1, 2'd1};
      vecs[11] = '{1'b0, 9'd0,  3'b001, 9'd24,  3'b000, 2'd0, 3'b001, 2'd0, 1'b0, 1'b0, 2'd0};
      vecs[12] = '{1'b0, 9'd0,  3'b001, 9'd24,  3'b001, 2'd3, 3'b001, 2'd3, 1'b0, 1'b0, 2'd0};
      vecs[13] = '{1'b1, 9'd24, 3'b000, 9'd0,   3'b000, 2'd0, 3'b000, 2'd0, 1'b0, 1'b1, 2'd3};

      doReset();

      for (int v = 0; v < 14; v++) begin
         applyStimulus(vecs[v].dr, vecs[v].da, vecs[v].r, {3{vecs[v].a}}, vecs[v].we, {3{vecs[v].wd}});
         checkOutput($sformatf("vec%0d_gnt", v), got_gnt, vecs[v].eg);
         checkOutput($sformatf("vec%0d_rd_valid", v), rd_valid, vecs[v].eg);
         if (vecs[v].eg != 3'b000) checkOutput($sformatf("vec%0d_rd_data", v), rd_data, vecs[v].erd);
         checkOutput($sformatf("vec%0d_addr_err", v), addr_err, vecs[v].eerr);
         checkOutput($sformatf("vec%0d_disp_valid", v), disp_valid, vecs[v].edv);
         if (vecs[v].edv) checkOutput($sformatf("vec%0d_disp_data", v), disp_data, vecs[v].edd);
         checkOutput($sformatf("vec%0d_disp_miss", v), disp_miss, 1'b0);
      end

`ifndef TILE_MAP_STATS_EN
      checkOutput("stat_tied_zero", stat_cnt, 48'd0);
`endif

      // Round-robin with all three requesting and no display.
      doReset();
      rr_exp[0] = 3'b001;
      rr_exp[1] = 3'b010;
      rr_exp[2] = 3'b100;
      rr_exp[3] = 3'b001;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 9'd0, 3'b111, {9'd22, 9'd21, 9'd0}, 3'b000, 6'd0);
         checkOutput($sformatf("rr%0d_gnt", c), got_gnt, rr_exp[c]);
         checkOutput($sformatf("rr%0d_rd_valid", c), rd_valid, rr_exp[c]);
      end

      // Display held busy: req0 must break through on its 16th waiting cycle.
      doReset();
      grant_cycle = 0;
      found = 1'b0;
      for (int c = 1; c <= 20 && !found; c++) begin
         applyStimulus(1'b1, 9'd23, 3'b001, {3{9'd0}}, 3'b000, 6'd0);
         if (got_gnt[0]) begin
            found = 1'b1;
            grant_cycle = c;
            checkOutput("starve_disp_miss", disp_miss, 1'b1);
            checkOutput("starve_disp_valid", disp_valid, 1'b0);
            checkOutput("starve_rd_valid", rd_valid, 3'b001);
            checkOutput("starve_rd_data", rd_data, 2'd1);
         end else begin
            checkOutput($sformatf("prestarve%0d_disp_valid", c), disp_valid, 1'b1);
         end
      end
      checkOutput("starve_grant_cycle", grant_cycle, 16);

      // Reset dropped while a write is being granted.
      doReset();
      @(negedge clk);
      req = 3'b100;
      req_we = 3'b100;
      req_addr = {9'd0, 9'd0, 9'd0};
      req_wdata = 6'd0;
      #1;
      checkOutput("abort_gnt", gnt, 3'b100);
      #2;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort_rd_valid", rd_valid, 3'b000);
      req = 3'b000;
      req_we = 3'b000;
      @(negedge clk);
      reset_n = 1'b1;
      modelReset();
      applyStimulus(1'b0, 9'd0, 3'b001, {3{9'd0}}, 3'b000, 6'd0);
      checkOutput("abort_map_rd_valid", rd_valid, 3'b001);
      checkOutput("abort_map_rd_data", rd_data, 2'd1);

      // Randomized traffic; requesters hold their request until granted.
      doReset();
      for (int i = 0; i < 3; i++) begin
         pend[i] = 1'b0;
         paddr[i] = '0;
         pwe[i] = 1'b0;
         pwd[i] = '0;
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic [2:0]  r;
         logic [2:0]  we;
         logic [26:0] ra;
         logic [5:0]  wd;
         for (int i = 0; i < 3; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               paddr[i] = 9'($urandom_range(0, 319));
               pwe[i] = 1'($urandom_range(0, 1));
               pwd[i] = 2'($urandom_range(0, 3));
            end
            r[i] = pend[i];
            we[i] = pwe[i];
            ra[9*i +: 9] = paddr[i];
            wd[2*i +: 2] = pwd[i];
         end
         applyStimulus($urandom_range(0, 9) < 7, 9'($urandom_range(0, 309)), r, ra, we, wd);
         compareAll($sformatf("rnd%0d", cyc));
         for (int i = 0; i < 3; i++)
            if (got_gnt[i]) pend[i] = 1'b0;
      end

`ifdef TILE_MAP_STATS_EN
      doReset();
      for (int c = 0; c < 5; c++)
         applyStimulus(1'b0, 9'd0, 3'b010, {3{9'd5}}, 3'b000, 6'd0);
      checkOutput("stat_req1_five", stat_cnt[31:16], 16'd5);
      for (int c = 0; c < 70000; c++)
         applyStimulus(1'b0, 9'd0, 3'b001, {3{9'd0}}, 3'b000, 6'd0);
      checkOutput("stat_req0_saturated", stat_cnt[15:0], 16'hFFFF);
      checkOutput("stat_req1_held", stat_cnt[31:16], 16'd5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
